// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg: shared game state encoding and defaults.
// No ports; imported by the sequencer.
package game_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAYING  = 2'd1,
    DYING    = 2'd2,
    GAMEOVER = 2'd3
  } game_state_t;

  localparam int TICK_DIV_DEFAULT    = 500000;
  localparam int DEATH_TICKS_DEFAULT = 50;
  localparam int SCORE_W             = 11;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running 0..DIV-1 counter with sync clear.
// Ports: clk, reset, clear in; wrap out (high when count==DIV-1).
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;

  assign wrap = (count == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || wrap)
      count <= '0;
    else
      count <= count + CW'(1);
  end

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: round FSM, movement tick, flap gating and scoring.
// Ports: clk, reset, flap, collision, pass_event in; state, world_rst,
// tick, flap_pulse, score, best, score_wr out (all registered).
module game_sequencer #(
  parameter int TICK_DIV    = game_sequencer_pkg::TICK_DIV_DEFAULT,
  parameter int DEATH_TICKS = game_sequencer_pkg::DEATH_TICKS_DEFAULT,
  parameter int SCORE_W     = game_sequencer_pkg::SCORE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flap,
  input  logic               collision,
  input  logic               pass_event,
  output logic [1:0]         state,
  output logic               world_rst,
  output logic               tick,
  output logic               flap_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best,
  output logic               score_wr
);

  import game_sequencer_pkg::*;

  localparam int DCW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_t        state_q, state_n;
  logic               flap_q, flap_edge;
  logic               wrap, div_clear, death_last;
  logic [DCW-1:0]     death_cnt, death_n;
  logic [SCORE_W-1:0] score_n;
  logic               tick_n, pulse_n, wr_n;

  assign flap_edge  = flap & ~flap_q;
  assign death_last = (death_cnt == DCW'(DEATH_TICKS - 1));

  // Divider restarts on round start and on DYING entry, so the death
  // sequence always lasts a whole number of tick periods.
  assign div_clear = (state_q == IDLE) || (state_q == GAMEOVER) ||
                     ((state_q == PLAYING) && collision);

  tick_divider #(
    .DIV (TICK_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (div_clear),
    .wrap  (wrap)
  );

  always_comb begin
    state_n = state_q;
    score_n = score;
    death_n = death_cnt;
    tick_n  = 1'b0;
    pulse_n = 1'b0;
    wr_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flap_edge) begin
          state_n = PLAYING;
          score_n = '0;
          pulse_n = 1'b1;
        end
      end
      PLAYING: begin
        if (collision) begin
          state_n = DYING;
          death_n = '0;
        end else begin
          tick_n  = wrap;
          pulse_n = flap_edge;
          if (pass_event && score != SCORE_MAX)
            score_n = score + SCORE_W'(1);
        end
      end
      DYING: begin
        if (wrap) begin
          if (death_last) begin
            state_n = GAMEOVER;
            wr_n    = 1'b1;
          end else begin
            death_n = death_cnt + DCW'(1);
          end
        end
      end
      GAMEOVER: begin
        if (flap_edge)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      flap_q     <= 1'b0;
      death_cnt  <= '0;
      score      <= '0;
      best       <= '0;
      tick       <= 1'b0;
      flap_pulse <= 1'b0;
      score_wr   <= 1'b0;
      world_rst  <= 1'b1;
    end else begin
      state_q    <= state_n;
      flap_q     <= flap;
      death_cnt  <= death_n;
      score      <= score_n;
      tick       <= tick_n;
      flap_pulse <= pulse_n;
      score_wr   <= wr_n;
      world_rst  <= (state_n == IDLE);
      // best follows score_wr by one cycle
      if (score_wr && score > best)
        best <= score;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: self-checking bench for game_sequencer.
// Directed scenarios plus random traffic against a timing model.
module tb_game_sequencer;

  localparam int T   = 4;
  localparam int D   = 3;
  localparam int SW  = 11;
  localparam int MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flap = 1'b0;
  logic          collision = 1'b0;
  logic          pass_event = 1'b0;
  logic [1:0]    state;
  logic          world_rst, tick, flap_pulse, score_wr;
  logic [SW-1:0] score, best;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // model: mode 0..3, cycles spent in current mode, scores
  int m_state, m_age, m_score, m_best;
  bit m_prev, m_pend, m_tick, m_pulse, m_wr;

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_DIV    (T),
    .DEATH_TICKS (D),
    .SCORE_W     (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flap       (flap),
    .collision  (collision),
    .pass_event (pass_event),
    .state      (state),
    .world_rst  (world_rst),
    .tick       (tick),
    .flap_pulse (flap_pulse),
    .score      (score),
    .best       (best),
    .score_wr   (score_wr)
  );

  function automatic logic [27:0] got_vec();
    return {state, world_rst, tick, flap_pulse, score, best, score_wr};
  endfunction

  function automatic logic [27:0] exp_vec();
    logic [1:0]    s;
    logic [SW-1:0] sc, bs;
    s  = 2'(m_state);
    sc = SW'(m_score);
    bs = SW'(m_best);
    return {s, m_state == 0, m_tick, m_pulse, sc, bs, m_wr};
  endfunction

  task automatic model_reset();
    m_state = 0; m_age = 0; m_score = 0; m_best = 0;
    m_prev = 0; m_pend = 0; m_tick = 0; m_pulse = 0; m_wr = 0;
  endtask

  // Predicts the outputs visible after the next clock edge.
  task automatic model_step(input bit f, input bit p, input bit c);
    bit e;
    e = f && !m_prev;
    m_prev = f;
    m_tick = 0; m_pulse = 0; m_wr = 0;
    if (m_pend) begin
      if (m_score > m_best) m_best = m_score;
      m_pend = 0;
    end
    case (m_state)
      0: if (e) begin
        m_state = 1; m_age = 0; m_score = 0; m_pulse = 1;
      end
      1: if (c) begin
        m_state = 2; m_age = 0;
      end else begin
        m_pulse = e;
        if (p && m_score < MAX) m_score++;
        m_tick = ((m_age + 1) % T) == 0;
        m_age++;
      end
      2: if (m_age + 1 == D * T) begin
        m_state = 3; m_age = 0; m_wr = 1; m_pend = 1;
      end else begin
        m_age++;
      end
      default: if (e) begin
        m_state = 0; m_age = 0;
      end
    endcase
  endtask

  task automatic drive(input bit f, input bit p, input bit c);
    flap = f; pass_event = p; collision = c;
    model_step(f, p, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; flap = 0; pass_event = 0; collision = 0;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, $urandom_range(0, 1), $urandom_range(0, 1));
      cmp_cnt++;
      if (got_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL reset_idle[%0d]: got %h required %h",
                 i, got_vec(), exp_vec());
      end
      cmp_cnt++;
      if ({state, world_rst, tick, score, best} !== {2'd0, 1'b1, 1'b0, 22'd0}) begin
        err_cnt++;
        $display("FAIL reset_const[%0d]: st=%0d wr=%b tk=%b sc=%0d bs=%0d required 0/1/0/0/0",
                 i, state, world_rst, tick, score, best);
      end
    end
  endtask

  task automatic test_start();
    drive(1, 0, 0);
    cmp_cnt++;
    if ({state, world_rst, flap_pulse} !== 4'b0101) begin
      err_cnt++;
      $display("FAIL start: st=%0d wrst=%b pulse=%b required 1/0/1",
               state, world_rst, flap_pulse);
    end
    for (int i = 1; i <= 12; i++) begin
      drive(1, 0, 0);
      cmp_cnt++;
      if ({tick, flap_pulse} !== {(i % T) == 0, 1'b0}) begin
        err_cnt++;
        $display("FAIL tick_period[%0d]: tick=%b pulse=%b required %b/0",
                 i, tick, flap_pulse, (i % T) == 0);
      end
    end
  endtask

  task automatic test_score_death();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0);
      drive(0, 0, 0);
    end
    drive(0, 1, 1);
    cmp_cnt++;
    if ({state, score} !== {2'd2, 11'd3}) begin
      err_cnt++;
      $display("FAIL collide: st=%0d score=%0d required 2/3", state, score);
    end
    for (int i = 1; i <= D * T; i++) begin
      drive(0, 1'($urandom), 1'($urandom));
      cmp_cnt++;
      if ({state, score_wr} !== {(i == D * T) ? 2'd3 : 2'd2, i == D * T}) begin
        err_cnt++;
        $display("FAIL dying[%0d]: st=%0d wr=%b", i, state, score_wr);
      end
    end
    drive(0, 0, 0);
    cmp_cnt++;
    if ({score_wr, best, score} !== {1'b0, 11'd3, 11'd3}) begin
      err_cnt++;
      $display("FAIL best1: wr=%b best=%0d score=%0d required 0/3/3",
               score_wr, best, score);
    end
  endtask

  task automatic test_second_round();
    int wr_seen;
    wr_seen = 0;
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 1, 0);
    drive(0, 0, 1);
    for (int i = 0; i < D * T + 3; i++) begin
      drive(0, 0, 0);
      wr_seen += int'(score_wr);
      cmp_cnt++;
      if (got_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL round2[%0d]: got %h required %h",
                 i, got_vec(), exp_vec());
      end
    end
    cmp_cnt++;
    if ({wr_seen, best, score, state} !== {32'd1, 11'd3, 11'd1, 2'd3}) begin
      err_cnt++;
      $display("FAIL round2_end: wr_pulses=%0d best=%0d score=%0d st=%0d required 1/3/1/3",
               wr_seen, best, score, state);
    end
  endtask

  task automatic test_saturation();
    drive(1, 0, 0);
    drive(0, 0, 0);
    drive(1, 0, 0);
    for (int i = 0; i < (1 << SW) + 5; i++) begin
      drive(1'($urandom), 1, 0);
      if (i % 256 == 0 || i > (1 << SW) - 3) begin
        cmp_cnt++;
        if (got_vec() !== exp_vec()) begin
          err_cnt++;
          $display("FAIL sat[%0d]: got %h required %h",
                   i, got_vec(), exp_vec());
        end
      end
    end
    cmp_cnt++;
    if (score !== 11'd2047) begin
      err_cnt++;
      $display("FAIL sat_final: score=%0d required 2047", score);
    end
  endtask

  task automatic test_random();
    bit f;
    f = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) f = ~f;
      drive(f, $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0);
      cmp_cnt++;
      if (got_vec() !== exp_vec()) begin
        err_cnt++;
        $display("FAIL random[%0d]: got %h required %h",
                 i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_dying();
    int n;
    n = 0;
    // finish any round so best becomes non-zero before the reset
    drive(0, 0, 1);
    while (state != 2'd3 && n < 200) begin
      drive(n % 2 == 0, 1, 1);
      n++;
    end
    drive(0, 0, 0);
    drive(1, 0, 0);
    while (state != 2'd1 && n < 400) begin
      drive(n % 2 == 0, 0, 0);
      n++;
    end
    drive(0, 1, 0);
    drive(0, 0, 1);
    drive(0, 0, 0);
    cmp_cnt++;
    if (state !== 2'd2 || best == '0) begin
      err_cnt++;
      $display("FAIL pre_reset: st=%0d best=%0d required 2/nonzero",
               state, best);
    end
    do_reset();
    cmp_cnt++;
    if (got_vec() !== {2'd0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_dying: got %h required %h",
               got_vec(), {2'd0, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0, 1'b0});
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_score_death();
    test_second_round();
    test_saturation();
    test_random();
    test_reset_dying();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
